// File: rtl/uart_fifo_core.sv
// uart_fifo_core: full-duplex UART with 16x-oversampled receiver, configurable framing and TX/RX FIFOs.
module uart_fifo_core #(
    parameter int CLK_FREQ   = 50_000_000,
    parameter int BAUD_RATE  = 9600,
    parameter int DATA_BITS  = 8,
    parameter int PARITY     = 0,
    parameter int FIFO_DEPTH = 16
) (
    input  logic                 clk,
    input  logic                 n_rst,
    input  logic                 tx_wr,
    input  logic [DATA_BITS-1:0] tx_data,
    output logic                 tx_full,
    output logic                 tx_busy,
    output logic                 tx,
    input  logic                 rx,
    input  logic                 rx_rd,
    output logic [DATA_BITS-1:0] rx_data,
    output logic                 rx_par_err,
    output logic                 rx_empty,
    output logic                 frame_err,
    output logic                 overrun,
    input  logic                 err_clr
);
    localparam int DIV_RAW = CLK_FREQ / (BAUD_RATE * 16);
    localparam int DIV = DIV_RAW < 1 ? 1 : DIV_RAW;
    localparam int CW = DIV > 1 ? $clog2(DIV) : 1;
    localparam int AW = $clog2(FIFO_DEPTH);
    localparam logic PODD = PARITY == 2;
    localparam logic [2:0] LAST_BIT = 3'(DATA_BITS - 1);

    typedef enum logic [2:0] {IDLE, START, DATA, PAR, STOP} state_t;

    logic [CW-1:0] div_cnt;
    logic tick;
    assign tick = div_cnt == CW'(DIV - 1);
    always_ff @(posedge clk or negedge n_rst)
        if (!n_rst) div_cnt <= '0;
        else div_cnt <= tick ? '0 : div_cnt + 1'b1;

    logic [DATA_BITS-1:0] tx_mem [FIFO_DEPTH];
    logic [DATA_BITS-1:0] tx_head, tx_sh;
    logic [AW:0] tx_wp, tx_rp;
    logic tx_empty, tx_pop, tx_we, tx_par, tx_end;
    logic [3:0] tx_tcnt;
    logic [2:0] tx_bit;
    state_t tx_state, tx_next;

    assign tx_empty = tx_wp == tx_rp;
    assign tx_full = (tx_wp[AW] != tx_rp[AW]) && (tx_wp[AW-1:0] == tx_rp[AW-1:0]);
    assign tx_head = tx_mem[tx_rp[AW-1:0]];
    assign tx_end = tick && tx_tcnt == 4'd15;
    // popping straight out of STOP keeps back-to-back frames gapless
    assign tx_pop = !tx_empty && tick && (tx_state == IDLE || (tx_state == STOP && tx_tcnt == 4'd15));
    assign tx_we = tx_wr && (!tx_full || tx_pop);
    assign tx_busy = tx_state != IDLE || !tx_empty;

    always_ff @(posedge clk)
        if (tx_we) tx_mem[tx_wp[AW-1:0]] <= tx_data;

    always_comb begin
        tx_next = tx_state;
        tx = 1'b1;
        case (tx_state)
            IDLE:  if (tx_pop) tx_next = START;
            START: begin
                tx = 1'b0;
                if (tx_end) tx_next = DATA;
            end
            DATA: begin
                tx = tx_sh[0];
                if (tx_end && tx_bit == LAST_BIT) tx_next = PARITY != 0 ? PAR : STOP;
            end
            PAR: begin
                tx = tx_par;
                if (tx_end) tx_next = STOP;
            end
            STOP:    if (tx_end) tx_next = tx_pop ? START : IDLE;
            default: tx_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge n_rst)
        if (!n_rst) begin
            tx_state <= IDLE;
            tx_wp <= '0;
            tx_rp <= '0;
            tx_tcnt <= '0;
            tx_bit <= '0;
            tx_sh <= '0;
            tx_par <= 1'b0;
        end else begin
            tx_state <= tx_next;
            if (tx_we) tx_wp <= tx_wp + 1'b1;
            if (tx_pop) begin
                tx_rp <= tx_rp + 1'b1;
                tx_sh <= tx_head;
                tx_par <= ^tx_head ^ PODD;
                tx_tcnt <= '0;
                tx_bit <= '0;
            end else if (tick) begin
                tx_tcnt <= tx_tcnt + 1'b1;
                if (tx_state == DATA && tx_tcnt == 4'd15) begin
                    tx_sh <= tx_sh >> 1;
                    tx_bit <= tx_bit + 1'b1;
                end
            end
        end

    logic rx_s1, rx_s2, rx_s3;
    logic [DATA_BITS:0] rx_mem [FIFO_DEPTH];
    logic [DATA_BITS:0] rx_head;
    logic [DATA_BITS-1:0] rx_sh;
    logic [AW:0] rx_wp, rx_rp;
    logic rx_full, rx_pop, rx_push, rx_we, rx_mid, rx_end, rx_pbit, rx_perr;
    logic [3:0] rx_tcnt;
    logic [2:0] rx_bit;
    state_t rx_state, rx_next;

    assign rx_empty = rx_wp == rx_rp;
    assign rx_full = (rx_wp[AW] != rx_rp[AW]) && (rx_wp[AW-1:0] == rx_rp[AW-1:0]);
    assign rx_head = rx_mem[rx_rp[AW-1:0]];
    assign rx_data = rx_empty ? '0 : rx_head[DATA_BITS-1:0];
    assign rx_par_err = !rx_empty && rx_head[DATA_BITS];
    assign rx_mid = tick && rx_tcnt == 4'd7;
    assign rx_end = tick && rx_tcnt == 4'd15;
    assign rx_perr = (PARITY != 0) && (rx_pbit ^ (^rx_sh) ^ PODD);
    assign rx_push = rx_state == STOP && rx_end && rx_s2;
    assign rx_pop = rx_rd && !rx_empty;
    assign rx_we = rx_push && (!rx_full || rx_pop);

    always_ff @(posedge clk)
        if (rx_we) rx_mem[rx_wp[AW-1:0]] <= {rx_perr, rx_sh};

    always_comb begin
        rx_next = rx_state;
        case (rx_state)
            IDLE:    if (rx_s3 && !rx_s2) rx_next = START;
            START:   if (rx_mid) rx_next = rx_s2 ? IDLE : DATA;
            DATA:    if (rx_end && rx_bit == LAST_BIT) rx_next = PARITY != 0 ? PAR : STOP;
            PAR:     if (rx_end) rx_next = STOP;
            STOP:    if (rx_end) rx_next = IDLE;
            default: rx_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge n_rst)
        if (!n_rst) begin
            {rx_s3, rx_s2, rx_s1} <= 3'b111;
            rx_state <= IDLE;
            rx_wp <= '0;
            rx_rp <= '0;
            rx_tcnt <= '0;
            rx_bit <= '0;
            rx_sh <= '0;
            rx_pbit <= 1'b0;
            frame_err <= 1'b0;
            overrun <= 1'b0;
        end else begin
            {rx_s3, rx_s2, rx_s1} <= {rx_s2, rx_s1, rx};
            rx_state <= rx_next;
            // after the mid-start sample the count restarts so later samples land mid-bit
            if (rx_state == IDLE || (rx_state == START && rx_mid)) rx_tcnt <= '0;
            else if (tick) rx_tcnt <= rx_tcnt + 1'b1;
            if (rx_state == START) rx_bit <= '0;
            if (rx_state == DATA && rx_end) begin
                rx_sh <= {rx_s2, rx_sh[DATA_BITS-1:1]};
                rx_bit <= rx_bit + 1'b1;
            end
            if (rx_state == PAR && rx_end) rx_pbit <= rx_s2;
            if (rx_we) rx_wp <= rx_wp + 1'b1;
            if (rx_pop) rx_rp <= rx_rp + 1'b1;
            frame_err <= err_clr ? 1'b0 : frame_err | (rx_state == STOP && rx_end && !rx_s2);
            overrun <= err_clr ? 1'b0 : overrun | (rx_push && rx_full && !rx_pop);
        end
endmodule

// File: tb/tb_uart_fifo_core.sv
// tb_uart_fifo_core: directed scoreboard bench for uart_fifo_core at 16 clk per bit.
module tb_uart_fifo_core;
    logic clk = 0, n_rst = 0, tx_wr = 0, rx_rd = 0, err_clr = 0;
    logic loop = 0, rx_drv = 1, rx2 = 1, rd2 = 0;
    logic [7:0] tx_data = 0;
    logic tx_full, tx_busy, tx, rx_par_err, rx_empty, frame_err, overrun, rx_line;
    logic [7:0] rx_data, rx_data2;
    logic tx_full2, tx_busy2, tx2, rx_par_err2, rx_empty2, frame_err2, overrun2;
    int n_chk = 0, n_fail = 0, busy;
    logic [8:0] sb[$];
    logic tq[$];
    logic [10:0] fb;

    assign rx_line = loop ? tx : rx_drv;

    uart_fifo_core #(.CLK_FREQ(1_600_000), .BAUD_RATE(100_000), .DATA_BITS(8), .PARITY(1), .FIFO_DEPTH(16)) dut (
        .clk(clk), .n_rst(n_rst), .tx_wr(tx_wr), .tx_data(tx_data), .tx_full(tx_full), .tx_busy(tx_busy),
        .tx(tx), .rx(rx_line), .rx_rd(rx_rd), .rx_data(rx_data), .rx_par_err(rx_par_err), .rx_empty(rx_empty),
        .frame_err(frame_err), .overrun(overrun), .err_clr(err_clr));

    uart_fifo_core #(.CLK_FREQ(1_600_000), .BAUD_RATE(100_000), .DATA_BITS(8), .PARITY(2), .FIFO_DEPTH(16)) dut2 (
        .clk(clk), .n_rst(n_rst), .tx_wr(1'b0), .tx_data(8'h00), .tx_full(tx_full2), .tx_busy(tx_busy2),
        .tx(tx2), .rx(rx2), .rx_rd(rd2), .rx_data(rx_data2), .rx_par_err(rx_par_err2), .rx_empty(rx_empty2),
        .frame_err(frame_err2), .overrun(overrun2), .err_clr(1'b0));

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic cyc(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic wr(input logic [7:0] d);
        tx_data = d;
        tx_wr = 1;
        @(negedge clk);
        tx_wr = 0;
    endtask

    task automatic send(input logic [7:0] d, input logic p, input logic s, input bit to2);
        logic [10:0] b;
        b = {s, p, d, 1'b0};
        for (int i = 0; i < 11; i++) begin
            if (to2) rx2 = b[i];
            else rx_drv = b[i];
            cyc(16);
        end
        rx2 = 1;
        rx_drv = 1;
    endtask

    task automatic drain(input int n, input string tag);
        for (int k = 0; k < n; k++) begin
            int t = 0;
            while (rx_empty && t < 600) begin
                @(negedge clk);
                t++;
            end
            if (rx_empty) begin
                chk({tag, "_timeout"}, rx_empty, 0);
                return;
            end
            chk({tag, "_word"}, {rx_par_err, rx_data}, sb.pop_front());
            rx_rd = 1;
            @(negedge clk);
            rx_rd = 0;
        end
    endtask

    task automatic count_busy();
        while (tx_busy && busy < 4000) begin
            tq.push_back(tx);
            @(negedge clk);
            busy++;
        end
    endtask

    initial begin
        cyc(3);
        chk("rst_tx", tx, 1);
        chk("rst_tx_busy", tx_busy, 0);
        chk("rst_tx_full", tx_full, 0);
        chk("rst_rx_empty", rx_empty, 1);
        chk("rst_frame_err", frame_err, 0);
        chk("rst_overrun", overrun, 0);
        chk("rst_rx_data", rx_data, 0);
        chk("rst_rx_par_err", rx_par_err, 0);
        n_rst = 1;
        loop = 1;
        cyc(2);

        // single frame, even parity: trace tx at mid-bit
        wr(8'hA5);
        sb.push_back({1'b0, 8'hA5});
        busy = 0;
        tq.delete();
        count_busy();
        chk("t1_frame_len", busy, 177);
        fb = {1'b1, ^8'hA5, 8'hA5, 1'b0};
        for (int i = 0; i < 11; i++) chk($sformatf("t1_bit%0d", i), tq.size() > 9 + 16 * i ? tq[9 + 16 * i] : 1'bx, fb[i]);
        chk("t1_idle_tx", tx, 1);
        drain(1, "t1");

        // three back-to-back frames: total busy time proves no idle gap
        wr(8'h00);
        wr(8'hFF);
        wr(8'h3C);
        sb.push_back(9'h000);
        sb.push_back(9'h0FF);
        sb.push_back(9'h03C);
        busy = 2;
        count_busy();
        chk("t2_gapless", busy, 3 * 176 + 1);
        drain(3, "t2");

        // overfill TX FIFO while a frame is in flight
        wr(8'h11);
        sb.push_back(9'h011);
        cyc(3);
        for (int i = 0; i < 17; i++) begin
            chk($sformatf("t3_full%0d", i), tx_full, i == 16);
            wr(8'h20 + 8'(i));
            if (i < 16) sb.push_back({1'b0, 8'h20 + 8'(i)});
        end
        drain(17, "t3");
        cyc(250);
        chk("t3_dropped", rx_empty, 1);

        loop = 0;
        cyc(5);
        // RX overrun without reads
        for (int i = 0; i < 17; i++) begin
            logic [7:0] d;
            d = 8'h40 + 8'(i * 3);
            send(d, ^d, 1, 0);
            if (i < 16) sb.push_back({1'b0, d});
            if (i == 15) chk("t4_no_overrun", overrun, 0);
        end
        cyc(5);
        chk("t4_overrun", overrun, 1);
        chk("t4_no_frame_err", frame_err, 0);
        drain(16, "t4");
        chk("t4_empty", rx_empty, 1);
        err_clr = 1;
        cyc(1);
        err_clr = 0;
        chk("t4_overrun_clr", overrun, 0);

        // framing error and odd parity
        send(8'h55, ^8'h55, 0, 0);
        cyc(5);
        chk("t5_frame_err", frame_err, 1);
        chk("t5_discarded", rx_empty, 1);
        err_clr = 1;
        cyc(1);
        err_clr = 0;
        chk("t5_frame_clr", frame_err, 0);
        send(8'h0F, 1'b0, 1, 1);
        cyc(3);
        chk("t5_odd_pushed", rx_empty2, 0);
        chk("t5_odd_data", rx_data2, 8'h0F);
        chk("t5_odd_bad_par", rx_par_err2, 1);
        rd2 = 1;
        cyc(1);
        rd2 = 0;
        send(8'h0F, 1'b1, 1, 1);
        cyc(3);
        chk("t5_odd_good_par", rx_par_err2, 0);
        chk("t5_odd_data2", rx_data2, 8'h0F);

        // short low glitch is rejected
        rx_drv = 0;
        cyc(4);
        rx_drv = 1;
        cyc(300);
        chk("t6_glitch_empty", rx_empty, 1);
        chk("t6_glitch_frame", frame_err, 0);

        // asynchronous reset mid-frame
        send(8'h12, ^8'h12, 1, 0);
        cyc(3);
        chk("t6_rx_loaded", rx_empty, 0);
        wr(8'h77);
        wr(8'h78);
        wr(8'h79);
        cyc(40);
        chk("t6_mid_frame", tx_busy, 1);
        #2 n_rst = 0;
        #1;
        chk("t6_rst_tx", tx, 1);
        chk("t6_rst_busy", tx_busy, 0);
        chk("t6_rst_rx_empty", rx_empty, 1);
        chk("t6_rst_tx_full", tx_full, 0);
        cyc(2);
        n_rst = 1;
        cyc(2);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
